ram512_fifo_ctrl: RTL and testbench

//   Sequencer sitting directly upstream of ram512: turns a push/pop FIFO interface

---
 rtl/ram512_fifo_ctrl_pkg.sv | 17 +
 rtl/fifo_arb_rr.sv | 38 +++
 rtl/ram512_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_ram512_fifo_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ram512_fifo_ctrl_pkg.sv
// Shared constants and encodings for the ram512 FIFO sequencer.
// The memory geometry is fixed by ram512: 512 words of 16 bits.
package ram512_fifo_ctrl_pkg;
   localparam int AW    = 9;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic {
      GNT_PUSH = 1'b0,
      GNT_POP  = 1'b1
   } side_e;
endpackage

// File: rtl/fifo_arb_rr.sv
// Two-requester round-robin arbiter for the single ram512 port.
// The history bit only moves when both sides contend, so one-sided traffic never shifts priority.
module fifo_arb_rr
   import ram512_fifo_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_push,
   input  logic req_pop,
   output logic gnt_push,
   output logic gnt_pop
);
   side_e rr_last_q, rr_last_d;

   always_comb begin
      gnt_push  = 1'b0;
      gnt_pop   = 1'b0;
      rr_last_d = rr_last_q;
      if (req_push && req_pop) begin
         if (rr_last_q == GNT_PUSH) begin
            gnt_pop   = 1'b1;
            rr_last_d = GNT_POP;
         end else begin
            gnt_push  = 1'b1;
            rr_last_d = GNT_PUSH;
         end
      end else begin
         gnt_push = req_push;
         gnt_pop  = req_pop;
      end
   end

   // Resetting to "push was last" hands the first conflict to pop.
   always_ff @(posedge clk) begin
      if (rst) rr_last_q <= GNT_PUSH;
      else     rr_last_q <= rr_last_d;
   end
endmodule

// File: rtl/ram512_fifo_ctrl.sv
// Push/pop FIFO sequencer driving the single-ported ram512; optionally zero-fills the RAM after reset.
// Owns the pointers, occupancy count, init counter and the registered pop data.
module ram512_fifo_ctrl
   import ram512_fifo_ctrl_pkg::*;
#(
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   output logic          push_ready,
   input  logic          pop,
   output logic          pop_ready,
   output logic          pop_valid,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic [AW-1:0] mem_add,
   output logic          mem_en,
   output logic          mem_w,
   output logic          mem_r,
   output logic [DW-1:0] mem_d_in,
   input  logic [DW-1:0] mem_d_out
);
   state_e        state_q, state_d;
   logic [AW-1:0] init_addr_q, init_addr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          pop_valid_q, pop_valid_d;
   logic [DW-1:0] pop_data_q, pop_data_d;
   logic [AW-1:0] mem_add_q, mem_add_d;
   logic [DW-1:0] mem_d_in_q, mem_d_in_d;
   logic          push_ok, pop_ok, gnt_push, gnt_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

   assign push_ok = (state_q == ST_RUN) && push && !full;
   assign pop_ok  = (state_q == ST_RUN) && pop && !empty;

   fifo_arb_rr u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_push (push_ok),
      .req_pop  (pop_ok),
      .gnt_push (gnt_push),
      .gnt_pop  (gnt_pop)
   );

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_valid_d = 1'b0;
      pop_data_d  = pop_data_q;
      mem_add_d   = mem_add_q;
      mem_d_in_d  = mem_d_in_q;
      mem_en      = 1'b0;
      mem_w       = 1'b0;
      mem_r       = 1'b0;
      if (state_q == ST_INIT) begin
         mem_en      = 1'b1;
         mem_w       = 1'b1;
         mem_add_d   = init_addr_q;
         mem_d_in_d  = '0;
         init_addr_d = init_addr_q + 1'b1;
         if (init_addr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end else if (gnt_push) begin
         mem_en     = 1'b1;
         mem_w      = 1'b1;
         mem_add_d  = wr_ptr_q;
         mem_d_in_d = push_data;
         wr_ptr_d   = wr_ptr_q + 1'b1;
         count_d    = count_q + 1'b1;
      end else if (gnt_pop) begin
         // ram512 reads combinationally, so the word is captured at this same edge.
         mem_en      = 1'b1;
         mem_r       = 1'b1;
         mem_add_d   = rd_ptr_q;
         pop_data_d  = mem_d_out;
         rd_ptr_d    = rd_ptr_q + 1'b1;
         count_d     = count_q - 1'b1;
         pop_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
         init_addr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         mem_add_q   <= '0;
         mem_d_in_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_valid_q <= pop_valid_d;
         pop_data_q  <= pop_data_d;
         mem_add_q   <= mem_add_d;
         mem_d_in_q  <= mem_d_in_d;
      end
   end

   // Address and write data hold their last driven value while the port is idle.
   assign mem_add    = mem_add_d;
   assign mem_d_in   = mem_d_in_d;
   assign push_ready = gnt_push;
   assign pop_ready  = gnt_pop;
   assign pop_valid  = pop_valid_q;
   assign pop_data   = pop_data_q;
   assign count      = count_q;
endmodule

// File: tb/tb_ram512_fifo_ctrl.sv
// Bench for ram512_fifo_ctrl with a behavioural ram512 array attached to the memory port.
// A queue-based FIFO model predicts grants; popped words go to a scoreboard drained by a monitor.
module tb_ram512_fifo_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0, pop = 1'b0;
   logic [15:0] push_data = '0;
   logic        push_ready, pop_ready, pop_valid, full, empty;
   logic [15:0] pop_data, mem_d_in, mem_d_out;
   logic [9:0]  count;
   logic [8:0]  mem_add;
   logic        mem_en, mem_w, mem_r;

   int checks = 0;
   int errors = 0;

   logic [15:0] ram [512];
   logic [15:0] model_q [$];
   logic [15:0] exp_q [$];
   int          n_push = 0, n_pop = 0;
   bit          m_last_push = 1'b1;
   bit          mon_en = 1'b0;
   logic        last_pop_ready;

   always #5 clk = ~clk;

   ram512_fifo_ctrl #(.CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .push_ready(push_ready),
      .pop(pop), .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_data(pop_data),
      .full(full), .empty(empty), .count(count), .mem_add(mem_add), .mem_en(mem_en),
      .mem_w(mem_w), .mem_r(mem_r), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
   );

   // ram512 stand-in: synchronous write, combinational read, junk when not reading.
   assign mem_d_out = (mem_en && mem_r) ? ram[mem_add] : 16'hDEAD;
   always @(posedge clk) if (mem_en && mem_w) ram[mem_add] <= mem_d_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every pop accepted before an edge must show up as pop_valid right after it.
   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         if (pop_valid) begin
            if (exp_q.size() == 0) chk("pop_valid_unexpected", 1, 0);
            else chk("pop_data", pop_data, exp_q.pop_front());
         end else if (exp_q.size() != 0) begin
            chk("pop_valid_missing", 0, 1);
            void'(exp_q.pop_front());
         end
      end
   end

   // One cycle of traffic; caller is just past a falling edge.
   task automatic step(input logic p, input logic q, input logic [15:0] d);
      bit push_ok, pop_ok, g_push, g_pop;
      push = p; pop = q; push_data = d;
      #1;
      push_ok = p && (model_q.size() < 512);
      pop_ok  = q && (model_q.size() > 0);
      g_pop   = pop_ok && !(push_ok && !m_last_push);
      g_push  = push_ok && !g_pop;
      last_pop_ready = pop_ready;
      chk("push_ready", push_ready, g_push);
      chk("pop_ready", pop_ready, g_pop);
      chk("count", count, model_q.size());
      chk("empty", empty, model_q.size() == 0);
      chk("full", full, model_q.size() == 512);
      if (mem_w && mem_r) chk("mem_w_and_mem_r", 1, 0);
      if (g_push) begin
         chk("push_add", mem_add, n_push % 512);
         chk("push_port", {mem_en, mem_w, mem_r}, 3'b110);
         chk("push_din", mem_d_in, d);
         model_q.push_back(d);
         n_push++;
      end else if (g_pop) begin
         chk("pop_add", mem_add, n_pop % 512);
         chk("pop_port", {mem_en, mem_w, mem_r}, 3'b101);
         exp_q.push_back(model_q.pop_front());
         n_pop++;
      end else begin
         chk("idle_port", mem_en, 0);
      end
      if (push_ok && pop_ok) m_last_push = g_push;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1; push = 1'b0; pop = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_q.delete(); exp_q.delete();
      n_push = 0; n_pop = 0; m_last_push = 1'b1;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_pop_valid", pop_valid, 0);
      chk("rst_pop_data", pop_data, 0);
      mon_en = 1'b1;
   endtask

   // Holds a push through INIT; the first push_ready marks the end of the zero-fill.
   task automatic run_init();
      int cyc = 0;
      int nz = 0;
      push = 1'b1; pop = 1'b0; push_data = 16'h1234;
      #0;
      while (!push_ready && cyc < 600) begin
         chk("init_add", mem_add, cyc % 512);
         chk("init_port", {mem_en, mem_w, mem_r, mem_d_in}, {3'b110, 16'h0});
         chk("init_pop_ready", pop_ready, 0);
         cyc++;
         @(posedge clk); @(negedge clk); #1;
      end
      chk("init_cycles", cyc, 512);
      foreach (ram[i]) if (ram[i] != 16'h0) nz++;
      chk("zero_fill_nonzero_words", nz, 0);
   endtask

   initial begin
      logic [3:0]  pattern;
      logic [15:0] fixed_words [3];
      fixed_words[0] = 16'hA5A5; fixed_words[1] = 16'h0001; fixed_words[2] = 16'hFFFF;
      foreach (ram[i]) ram[i] = 16'(($urandom % 65535) + 1);

      do_reset();
      run_init();
      step(1, 0, 16'h1234);
      step(0, 1, 16'h0);

      for (int i = 0; i < 3; i++) step(1, 0, fixed_words[i]);
      for (int i = 0; i < 3; i++) step(0, 1, 16'h0);
      step(0, 0, 16'h0);
      chk("after_fixed_empty", empty, 1);

      for (int i = 0; i < 512; i++) step(1, 0, 16'(i));
      chk("fill_full", full, 1);
      chk("fill_count", count, 512);
      step(1, 0, 16'hBAD0);
      for (int i = 0; i < 512; i++) step(0, 1, 16'h0);

      for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h0500 + i));
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 16'(16'h0600 + k));
         pattern[3-k] = last_pop_ready;
      end
      chk("rr_pattern", pattern, 4'b1010);
      chk("rr_count", count, 5);
      while (model_q.size() > 0) step(0, 1, 16'h0);

      step(1, 1, 16'hBEEF);
      step(0, 1, 16'h0);

      for (int seg = 0; seg < 3; seg++) begin
         int pb = (seg == 0) ? 70 : (seg == 1) ? 30 : 50;
         int qb = (seg == 0) ? 30 : (seg == 1) ? 70 : 50;
         for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) < pb, $urandom_range(0, 99) < qb, 16'($urandom));
      end
      while (model_q.size() > 0) step(0, 1, 16'h0);

      for (int i = 0; i < 8; i++) step(1, 0, 16'(16'h0700 + i));
      step(0, 1, 16'h0);
      chk("pre_rst_count", count, 7);
      do_reset();
      run_init();
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom));
      while (model_q.size() > 0) step(0, 1, 16'h0);
      step(0, 0, 16'h0);
      step(0, 0, 16'h0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
